experiment_generic_demux3_reg: RTL and testbench
================================================

Name: experiment_generic_demux3_reg

Overview:
- Registered 1-to-N demultiplexer with valid/ready handshaking; the inverse of the N-to-1 select mux.
- Steers one input word stream to one of N outputs by select index.
- Each output has a one-entry holding register, so outputs do not block each other.
- Used as an FPGA mapping experiment and as a building block for switch output steering in the NoC.

Parameters:
- N, 3, number of outputs.
- W, DEFAULT_D_W (common_pkg), width of each data word.
- L, $clog2(N) (localparam), select width.
- CW, 8, width of the dropped-word counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- s  input  L  destination index, sampled with i_valid.
- i  input  W  input data word.
- i_valid  input  1  input word present.
- i_ready  output  1  input word accepted this cycle when i_valid && i_ready.
- o  output  N*W  packed [N-1:0][W-1:0] per-output data.
- o_valid  output  N  per-output word present.
- o_ready  input  N  per-output consumer ready.
- drop_cnt  output  CW  count of words dropped for out-of-range s.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - o_valid=0, o=0, drop_cnt=0.
  - Reset takes priority over any same-cycle handshake.
  - Words held mid-transfer are discarded.
- State: per output k, a full flag (drives o_valid[k]) and a W-bit data register (drives o[k]). No other state apart from drop_cnt.
- Input ready (combinational, no dependency on i_valid):
  - If s<N: i_ready = !full[s] || o_ready[s].
  - If s>=N (reachable when N is not a power of 2, e.g. s=3 for N=3): i_ready=1.
- Accept, s<N: on i_valid && i_ready, register k=s loads i and full[k]=1 next cycle. Latency is one cycle from accept to o_valid[k].
- Drain: on o_valid[k] && o_ready[k], full[k] clears next cycle unless reloaded.
- Simultaneous drain and load of the same output: the register takes the new word and full stays 1. Full throughput is one word per cycle per output.
- Loads and drains on different outputs in the same cycle are independent.
- o[k] holds its value while full[k]=1 && !o_ready[k]. It must not change until the handshake completes.
- o[k] is don't-care but stable (last value) when o_valid[k]=0.
- Only one output can load per cycle, since there is a single input.
- Out-of-range s: the word is accepted and dropped. drop_cnt increments by 1 and saturates at 2^CW-1 (no wrap). No output changes.
- Ordering: words to the same output leave in acceptance order. There is no ordering guarantee across outputs.
- No combinational path from i or i_valid to o or o_valid. i_ready depends combinationally on s, full and o_ready only.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with i_valid=1, s=0, i=0xAA -> o_valid=000 and drop_cnt=0 during reset and on the first cycle after release.
- Single steer: i=0x11, s=2, i_valid=1, all o_ready=0 -> i_ready=1. Next cycle o_valid=100 and o[2]=0x11, and it holds for 5 cycles. Raise o_ready[2] -> o_valid[2]=0 next cycle.
- Backpressure: output 1 full with 0x22 and o_ready[1]=0, then present i=0x33, s=1 -> i_ready=0 and o[1] stays 0x22. Same cycle, s=0 is accepted (i_ready=1).
- Streaming: o_ready=111, send 0x01..0x08 with s=1 every cycle -> i_ready stays 1 and o[1] shows 0x01..0x08 on consecutive cycles, one cycle late, with no bubbles.
- Drop path: s=3 for 300 accepted words -> drop_cnt counts to 255 and stays there, with o_valid unchanged.
- Reset mid-operation: outputs 0 and 2 full, assert rst_n=0 for one cycle -> o_valid=000 next cycle. New word i=0x44, s=0 appears on o[0] one cycle after accept.

Source files
------------

// File: rtl/experiment_generic_demux3_reg.sv
// Registered 1-to-N demultiplexer with valid/ready handshaking.
// Each output owns a one-entry holding register; out-of-range selects are dropped and counted.

package common_pkg;
    localparam int DEFAULT_D_W = 8;
endpackage

module experiment_generic_demux3_reg
    import common_pkg::*;
#(
    parameter int N  = 3,
    parameter int W  = DEFAULT_D_W,
    parameter int CW = 8,
    localparam int L = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [L-1:0]          s,
    input  logic [W-1:0]          i,
    input  logic                  i_valid,
    output logic                  i_ready,
    output logic [N-1:0][W-1:0]   o,
    output logic [N-1:0]          o_valid,
    input  logic [N-1:0]          o_ready,
    output logic [CW-1:0]         drop_cnt
);

    logic [N-1:0]          full_q, full_d;
    logic [N-1:0][W-1:0]   data_q, data_d;
    logic [CW-1:0]         drop_q, drop_d;

    logic [N-1:0]          sel;
    logic                  s_in_range;
    logic                  accept;

    // One-hot decode of s avoids indexing per-output state with an out-of-range value.
    always_comb begin
        sel = '0;
        for (int k = 0; k < N; k++) begin
            sel[k] = (s == L'(k));
        end
        s_in_range = |sel;
    end

    always_comb begin
        if (s_in_range) begin
            i_ready = |(sel & (~full_q | o_ready));
        end else begin
            i_ready = 1'b1;
        end
        accept = i_valid && i_ready;
    end

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        drop_d = drop_q;
        for (int k = 0; k < N; k++) begin
            if (o_ready[k]) begin
                full_d[k] = 1'b0;
            end
            // A same-cycle load wins over the drain, keeping full throughput.
            if (accept && sel[k]) begin
                full_d[k] = 1'b1;
                data_d[k] = i;
            end
        end
        if (accept && !s_in_range && (drop_q != {CW{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= '0;
            data_q <= '0;
            drop_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            drop_q <= drop_d;
        end
    end

    always_comb begin
        o        = data_q;
        o_valid  = full_q;
        drop_cnt = drop_q;
    end

endmodule

// File: tb/tb_experiment_generic_demux3_reg.sv
// Directed self-checking bench for experiment_generic_demux3_reg (N=3, W=8, CW=8).
// Inputs change and outputs are sampled a little after each rising edge.

module tb_experiment_generic_demux3_reg;

    localparam int N  = 3;
    localparam int W  = common_pkg::DEFAULT_D_W;
    localparam int CW = 8;
    localparam int L  = 2;

    logic                 clk;
    logic                 rst_n;
    logic [L-1:0]         s;
    logic [W-1:0]         i;
    logic                 i_valid;
    logic                 i_ready;
    logic [N-1:0][W-1:0]  o;
    logic [N-1:0]         o_valid;
    logic [N-1:0]         o_ready;
    logic [CW-1:0]        drop_cnt;

    int passed = 0;
    int total  = 0;

    experiment_generic_demux3_reg #(.N(N), .W(W), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (s),
        .i        (i),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .o        (o),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic [L-1:0] sel, input logic [W-1:0] d,
                                 input logic v, input logic [N-1:0] rdy);
        rst_n   = r;
        s       = sel;
        i       = d;
        i_valid = v;
        o_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        // Reset held with a live input word that must be ignored.
        applyStimulus(1'b0, 2'd0, 8'hAA, 1'b1, 3'b000);
        tick();
        checkOutput("rst_o_valid_c1", 32'(o_valid), 32'h0);
        checkOutput("rst_drop_c1", 32'(drop_cnt), 32'h0);
        tick();
        checkOutput("rst_o_valid_c2", 32'(o_valid), 32'h0);
        checkOutput("rst_o0_c2", 32'(o[0]), 32'h0);
        applyStimulus(1'b1, 2'd0, 8'hAA, 1'b0, 3'b000);
        checkOutput("rel_o_valid", 32'(o_valid), 32'h0);
        checkOutput("rel_drop", 32'(drop_cnt), 32'h0);

        // Single steer to output 2.
        applyStimulus(1'b1, 2'd2, 8'h11, 1'b1, 3'b000);
        checkOutput("steer_i_ready", 32'(i_ready), 32'h1);
        tick();
        applyStimulus(1'b1, 2'd2, 8'h11, 1'b0, 3'b000);
        checkOutput("steer_o_valid", 32'(o_valid), 32'b100);
        checkOutput("steer_o2", 32'(o[2]), 32'h11);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("steer_hold_valid", 32'(o_valid), 32'b100);
            checkOutput("steer_hold_o2", 32'(o[2]), 32'h11);
        end
        applyStimulus(1'b1, 2'd2, 8'h11, 1'b0, 3'b100);
        tick();
        checkOutput("steer_drained", 32'(o_valid), 32'b000);

        // Backpressure on output 1 while output 0 stays free.
        applyStimulus(1'b1, 2'd1, 8'h22, 1'b1, 3'b000);
        checkOutput("bp_first_ready", 32'(i_ready), 32'h1);
        tick();
        applyStimulus(1'b1, 2'd1, 8'h33, 1'b1, 3'b000);
        checkOutput("bp_blocked_ready", 32'(i_ready), 32'h0);
        tick();
        checkOutput("bp_o1_held", 32'(o[1]), 32'h22);
        checkOutput("bp_o_valid", 32'(o_valid), 32'b010);
        applyStimulus(1'b1, 2'd0, 8'h55, 1'b1, 3'b000);
        checkOutput("bp_other_ready", 32'(i_ready), 32'h1);
        tick();
        applyStimulus(1'b1, 2'd0, 8'h55, 1'b0, 3'b000);
        checkOutput("bp_both_valid", 32'(o_valid), 32'b011);
        checkOutput("bp_o0", 32'(o[0]), 32'h55);
        checkOutput("bp_o1_still", 32'(o[1]), 32'h22);
        applyStimulus(1'b1, 2'd0, 8'h55, 1'b0, 3'b111);
        tick();
        checkOutput("bp_all_drained", 32'(o_valid), 32'b000);

        // Streaming into output 1 with the consumer always ready.
        for (int j = 1; j <= 8; j++) begin
            applyStimulus(1'b1, 2'd1, 8'(j), 1'b1, 3'b111);
            checkOutput("stream_i_ready", 32'(i_ready), 32'h1);
            if (j > 1) begin
                checkOutput("stream_o1", 32'(o[1]), 32'(j - 1));
                checkOutput("stream_valid", 32'(o_valid), 32'b010);
            end
            tick();
        end
        applyStimulus(1'b1, 2'd1, 8'h00, 1'b0, 3'b111);
        checkOutput("stream_last_o1", 32'(o[1]), 32'h08);
        checkOutput("stream_last_valid", 32'(o_valid), 32'b010);
        tick();
        checkOutput("stream_empty", 32'(o_valid), 32'b000);

        // Park a word in output 2, then hammer the out-of-range select.
        applyStimulus(1'b1, 2'd2, 8'h77, 1'b1, 3'b000);
        tick();
        applyStimulus(1'b1, 2'd3, 8'h99, 1'b1, 3'b000);
        checkOutput("drop_i_ready", 32'(i_ready), 32'h1);
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (n == 1)   checkOutput("drop_cnt_1", 32'(drop_cnt), 32'd1);
            if (n == 254) checkOutput("drop_cnt_254", 32'(drop_cnt), 32'd254);
            if (n == 255) checkOutput("drop_cnt_255", 32'(drop_cnt), 32'd255);
            if (n == 300) checkOutput("drop_cnt_sat", 32'(drop_cnt), 32'd255);
        end
        checkOutput("drop_o_valid", 32'(o_valid), 32'b100);
        checkOutput("drop_o2", 32'(o[2]), 32'h77);

        // Reset in the middle of traffic, then a fresh word.
        applyStimulus(1'b1, 2'd0, 8'h66, 1'b1, 3'b000);
        tick();
        checkOutput("mid_pre_valid", 32'(o_valid), 32'b101);
        applyStimulus(1'b0, 2'd0, 8'h44, 1'b1, 3'b000);
        tick();
        checkOutput("mid_rst_valid", 32'(o_valid), 32'b000);
        checkOutput("mid_rst_o0", 32'(o[0]), 32'h0);
        checkOutput("mid_rst_drop", 32'(drop_cnt), 32'h0);
        applyStimulus(1'b1, 2'd0, 8'h44, 1'b1, 3'b000);
        checkOutput("mid_new_ready", 32'(i_ready), 32'h1);
        tick();
        applyStimulus(1'b1, 2'd0, 8'h44, 1'b0, 3'b000);
        checkOutput("mid_new_valid", 32'(o_valid), 32'b001);
        checkOutput("mid_new_o0", 32'(o[0]), 32'h44);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
